// File: rtl/rsub_serial_word.sv
// ---------------------------------------------------------------------------
// rsub_serial_word
//
// Bit-serial word subtractor. On a start strobe it latches two WIDTH-bit
// unsigned operands and computes op_a - op_b LSB-first, one bit per clock,
// through a 1-bit full subtractor whose borrow lives in a flip-flop. When the
// last bit has been processed it presents the difference and the final borrow
// together with a one-cycle done pulse.
//
// Parameters
//   WIDTH          operand / result width in bits, 1..32 (default 8)
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        request strobe, sampled only while o_busy is low
//   i_op_a         minuend, sampled with i_start
//   i_op_b         subtrahend, sampled with i_start
//   o_busy         high while a subtraction is in progress (bit cycles)
//   o_done         one-cycle pulse in the cycle diff/borrow_out are updated
//   o_diff         op_a - op_b modulo 2^WIDTH
//   o_borrow_out   final borrow, 1 when op_a < op_b (unsigned)
//   o_dbg_state    current FSM state (0 IDLE, 1 SHIFT, 2 DONE) for checkers
//
// Handshake: a request is accepted on any rising edge where i_start is high
// and o_busy is low (IDLE or DONE). While o_busy is high i_start is ignored
// entirely; there is no queueing. Exactly one o_done pulse follows each
// accepted request, WIDTH+1 clocks after the accepting edge, unless a reset
// intervenes.
// ---------------------------------------------------------------------------
module rsub_serial_word #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic [1:0]       o_dbg_state
);

    // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_bq;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    // -----------------------------------------------------------------------
    // Combinational nets
    // -----------------------------------------------------------------------
    logic [1:0]       w_state_next;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bnext;
    logic [WIDTH-1:0] w_r_next;

    // A request is taken whenever we are not in the middle of a subtraction.
    assign w_accept = i_start && (r_state != S_SHIFT);
    assign w_last   = (r_cnt == LAST_BIT);

    // 1-bit full subtractor on the current LSBs and the stored borrow.
    assign w_d     = r_a[0] ^ r_b[0] ^ r_bq;
    assign w_bnext = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bq);

    // Result bit i is written straight to position i. This is exactly where
    // an MSB-in right-shift register would leave it after WIDTH shifts, and it
    // lets the final word be formed in the same cycle as the last bit.
    always_comb begin
        w_r_next        = r_r;
        w_r_next[r_cnt] = w_d;
    end

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // A start in the done cycle chains straight into the next
                // operation, giving one result every WIDTH+1 clocks.
                if (i_start) begin
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs (decoded from the state register only, so there
    // is no combinational path from any input to any output)
    // -----------------------------------------------------------------------
    always_comb begin
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            S_SHIFT: o_busy = 1'b1;
            S_DONE:  o_done = 1'b1;
            default: begin
                o_busy = 1'b0;
                o_done = 1'b0;
            end
        endcase
    end

    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow;
    assign o_dbg_state  = r_state;

    // -----------------------------------------------------------------------
    // Datapath: operand shift registers, result, counter, borrow flop
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_r   <= '0;
            r_cnt <= '0;
            r_bq  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= i_op_a;
            r_b   <= i_op_b;
            r_r   <= '0;
            r_cnt <= '0;
            r_bq  <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_r   <= w_r_next;
            r_cnt <= r_cnt + 1'b1;
            r_bq  <= w_bnext;
        end
    end

    // Visible results change only on the transition into DONE and hold
    // through IDLE and SHIFT until the next completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if ((r_state == S_SHIFT) && w_last) begin
            r_diff   <= w_r_next;
            r_borrow <= w_bnext;
        end
    end

endmodule

// File: tb/tb_rsub_serial_word.sv
// ---------------------------------------------------------------------------
// Testbench for rsub_serial_word: a WIDTH=8 instance and a WIDTH=1 instance
// sharing clock and reset. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
// ---------------------------------------------------------------------------
module tb_rsub_serial_word;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic       start;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
    logic [1:0] dbg_state;

    rsub_serial_word #(.WIDTH(8)) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .o_busy       (busy),
        .o_done       (done),
        .o_diff       (diff),
        .o_borrow_out (borrow_out),
        .o_dbg_state  (dbg_state)
    );

    // ---------------- WIDTH=1 instance ----------------
    logic       start1;
    logic [0:0] op_a1;
    logic [0:0] op_b1;
    logic       busy1;
    logic       done1;
    logic [0:0] diff1;
    logic       borrow1;
    logic [1:0] dbg_state1;

    rsub_serial_word #(.WIDTH(1)) u_dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start1),
        .i_op_a       (op_a1),
        .i_op_b       (op_b1),
        .o_busy       (busy1),
        .o_done       (done1),
        .o_diff       (diff1),
        .o_borrow_out (borrow1),
        .o_dbg_state  (dbg_state1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle start pulse; returns in bit cycle 0 (one clock after the
    // accepting edge).
    task automatic drive_start(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        step();
        start = 1'b0;
    endtask

    // Waits for done, bounded. cycles counts clocks since the accepting edge.
    task automatic wait_done(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        start = 0; op_a = 0; op_b = 0;
        start1 = 0; op_a1 = 0; op_b1 = 0;
        rst_n = 1'b0;
        step(); step();
        n_checks++;
        if ({busy, done, diff, borrow_out, dbg_state} !== 13'd0)
            $display("FAIL reset_w8: busy=%b done=%b diff=%h borrow=%b state=%0d expected all 0",
                     busy, done, diff, borrow_out, dbg_state);
        else n_pass++;
        n_checks++;
        if ({busy1, done1, diff1, borrow1, dbg_state1} !== 6'd0)
            $display("FAIL reset_w1: busy=%b done=%b diff=%b borrow=%b state=%0d expected all 0",
                     busy1, done1, diff1, borrow1, dbg_state1);
        else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive_start(8'h5A, 8'h23);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0)
                $display("FAIL basic_busy bit %0d: busy=%b done=%b expected busy=1 done=0", i, busy, done);
            else n_pass++;
            step();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'h37 || borrow_out !== 1'b0)
            $display("FAIL basic_done: done=%b busy=%b diff=%h borrow=%b expected 1 0 37 0",
                     done, busy, diff, borrow_out);
        else n_pass++;
        step();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h37)
            $display("FAIL basic_hold: done=%b busy=%b diff=%h expected 0 0 37", done, busy, diff);
        else n_pass++;
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'h00, 8'hFF, 8'h80};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h7F};
        logic [7:0] vd [3] = '{8'hFF, 8'h00, 8'h01};
        logic       vw [3] = '{1'b1, 1'b0, 1'b0};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            drive_start(va[i], vb[i]);
            n_checks++;
            if (diff !== vd[(i + 2) % 3] && i > 0)
                $display("FAIL vec%0d_hold_in_shift: diff=%h expected %h", i, diff, vd[(i + 2) % 3]);
            else n_pass++;
            wait_done(cyc);
            n_checks++;
            if (cyc !== 9 || diff !== vd[i] || borrow_out !== vw[i])
                $display("FAIL vec%0d: latency=%0d diff=%h borrow=%b expected 9 %h %b",
                         i, cyc, diff, borrow_out, vd[i], vw[i]);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_ignore_busy();
        int cyc;
        int extra;
        drive_start(8'h10, 8'h01);
        step(); step(); step();          // now in bit cycle 3
        start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
        step();
        start = 1'b0; op_a = 8'h00; op_b = 8'h00;
        wait_done(cyc);
        cyc = cyc + 4;
        n_checks++;
        if (cyc !== 9 || diff !== 8'h0F || borrow_out !== 1'b0)
            $display("FAIL ignore_busy: latency=%0d diff=%h borrow=%b expected 9 0f 0",
                     cyc, diff, borrow_out);
        else n_pass++;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0 || diff !== 8'h0F)
            $display("FAIL ignore_no_second: active_cycles=%0d diff=%h expected 0 0f", extra, diff);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        int bad;
        start = 1'b1; op_a = 8'h03; op_b = 8'h05;
        step();
        wait_done(cyc);
        n_checks++;
        if (cyc !== 9 || diff !== 8'hFE || borrow_out !== 1'b1)
            $display("FAIL b2b_first: latency=%0d diff=%h borrow=%b expected 9 fe 1", cyc, diff, borrow_out);
        else n_pass++;
        for (int j = 1; j <= 27; j++) begin
            step();
            n_checks++;
            bad = 0;
            if ((j % 9) == 0) begin
                if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'hFE || borrow_out !== 1'b1) bad = 1;
            end else begin
                if (done !== 1'b0 || busy !== 1'b1) bad = 1;
            end
            if (bad != 0)
                $display("FAIL b2b cycle %0d: done=%b busy=%b diff=%h borrow=%b expected done=%0d",
                         j, done, busy, diff, borrow_out, ((j % 9) == 0));
            else n_pass++;
        end
        start = 1'b0;
        for (int j = 0; j < 10; j++) step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL b2b_drain: busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        drive_start(8'hF0, 8'h0F);
        step(); step(); step(); step();  // bit cycle 4
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL reset_mid: busy=%b done=%b diff=%h borrow=%b state=%0d expected all 0",
                     busy, done, diff, borrow_out, dbg_state);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid_idle: busy=%b done=%b expected 0 0", busy, done);
        else n_pass++;
        drive_start(8'h0F, 8'hF0);
        wait_done(cyc);
        n_checks++;
        if (cyc !== 9 || diff !== 8'h1F || borrow_out !== 1'b1)
            $display("FAIL reset_mid_after: latency=%0d diff=%h borrow=%b expected 9 1f 1",
                     cyc, diff, borrow_out);
        else n_pass++;
        step();
    endtask

    task automatic test_width1();
        logic [1:0] exp_r [4] = '{2'b00, 2'b10, 2'b11, 2'b00}; // {diff, borrow}
        logic [1:0] pair;
        for (int i = 0; i < 4; i++) begin
            pair   = 2'(i);
            start1 = 1'b1;
            op_a1  = pair[0];
            op_b1  = pair[1];
            step();
            start1 = 1'b0;
            n_checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0)
                $display("FAIL w1_busy a=%b b=%b: busy=%b done=%b expected 1 0",
                         pair[0], pair[1], busy1, done1);
            else n_pass++;
            step();
            n_checks++;
            if (done1 !== 1'b1 || busy1 !== 1'b0 || {diff1, borrow1} !== exp_r[i])
                $display("FAIL w1_result a=%b b=%b: done=%b busy=%b diff=%b borrow=%b expected 1 0 %b %b",
                         pair[0], pair[1], done1, busy1, diff1, borrow1, exp_r[i][1], exp_r[i][0]);
            else n_pass++;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
